// File: rtl/mac_lut_lookup_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : mac_lut_lookup_arbiter_if
// Description : Requester-side and LUT-side bundle for the MAC LUT lookup
//               arbiter. The slave modport is the arbiter's view. The master
//               modport is the surrounding parsers and LUT.
// Revision    : 1.0 - initial release
// ============================================================================
interface mac_lut_lookup_arbiter_if #(
    parameter int NUM_REQ           = 4,
    parameter int NUM_OUTPUT_QUEUES = 8
);
    // requester side
    logic [NUM_REQ-1:0]                   req_valid;
    logic [NUM_REQ*48-1:0]                req_dst_mac;
    logic [NUM_REQ*48-1:0]                req_src_mac;
    logic [NUM_REQ*NUM_OUTPUT_QUEUES-1:0] req_src_port;
    logic [NUM_REQ-1:0]                   req_grant;
    logic [NUM_REQ-1:0]                   resp_valid;
    logic [NUM_OUTPUT_QUEUES-1:0]         resp_dst_ports;
    logic                                 resp_hit;
    logic                                 resp_timeout;
    // LUT side
    logic [47:0]                          lu_dst_mac;
    logic [47:0]                          lu_src_mac;
    logic [NUM_OUTPUT_QUEUES-1:0]         lu_src_port;
    logic                                 lu_req;
    logic [NUM_OUTPUT_QUEUES-1:0]         lu_dst_ports;
    logic                                 lu_done;
    logic                                 lu_hit;
    logic                                 lu_miss;
    // statistics
    logic [31:0]                          stat_lookups;
    logic [31:0]                          stat_hits;
    logic [31:0]                          stat_timeouts;

    modport slave (
        input  req_valid, req_dst_mac, req_src_mac, req_src_port,
        input  lu_dst_ports, lu_done, lu_hit, lu_miss,
        output req_grant, resp_valid, resp_dst_ports, resp_hit, resp_timeout,
        output lu_dst_mac, lu_src_mac, lu_src_port, lu_req,
        output stat_lookups, stat_hits, stat_timeouts
    );

    modport master (
        output req_valid, req_dst_mac, req_src_mac, req_src_port,
        output lu_dst_ports, lu_done, lu_hit, lu_miss,
        input  req_grant, resp_valid, resp_dst_ports, resp_hit, resp_timeout,
        input  lu_dst_mac, lu_src_mac, lu_src_port, lu_req,
        input  stat_lookups, stat_hits, stat_timeouts
    );
endinterface
`default_nettype wire

// File: rtl/mac_lut_lookup_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mac_lut_lookup_arbiter
// Description : Round-robin sharing of one MAC CAM LUT between NUM_REQ
//               requesters. Each lookup goes through init hold-off, a request
//               pulse, a wait for done with timeout, and a one-hot tagged
//               response. Lookup, hit and timeout counters are kept.
// Revision    : 1.0 - initial release
// ============================================================================
module mac_lut_lookup_arbiter #(
    parameter int                           NUM_REQ                   = 4,
    parameter int                           NUM_OUTPUT_QUEUES         = 8,
    parameter logic [NUM_OUTPUT_QUEUES-1:0] DEFAULT_MISS_OUTPUT_PORTS = 'h55,
    parameter int                           INIT_CYCLES               = 64,
    parameter int                           TIMEOUT_CYCLES            = 16
) (
    input wire logic                clk,
    input wire logic                reset,
    mac_lut_lookup_arbiter_if.slave bus
);
    localparam int          c_IDX_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [7:0]  c_INIT_LAST = 8'(INIT_CYCLES - 1);
    localparam logic [7:0]  c_TO_LAST   = 8'(TIMEOUT_CYCLES - 1);

    localparam logic [2:0]  c_ST_INIT  = 3'd0;
    localparam logic [2:0]  c_ST_IDLE  = 3'd1;
    localparam logic [2:0]  c_ST_ISSUE = 3'd2;
    localparam logic [2:0]  c_ST_WAIT  = 3'd3;
    localparam logic [2:0]  c_ST_RESP  = 3'd4;

    logic [2:0]                   r_state;
    logic [2:0]                   w_next_state;
    logic [7:0]                   r_init_cnt;
    logic [7:0]                   r_wait_cnt;
    logic [c_IDX_W-1:0]           r_rr_ptr;
    logic [c_IDX_W-1:0]           r_winner;
    logic [c_IDX_W-1:0]           w_cand;
    logic [c_IDX_W-1:0]           w_pick;
    logic                         w_found;
    logic [NUM_REQ-1:0]           w_winner_oh;
    logic [47:0]                  r_lu_dst_mac;
    logic [47:0]                  r_lu_src_mac;
    logic [NUM_OUTPUT_QUEUES-1:0] r_lu_src_port;
    logic [NUM_OUTPUT_QUEUES-1:0] r_resp_dst_ports;
    logic                         r_resp_hit;
    logic                         r_resp_timeout;
    logic [31:0]                  r_stat_lookups;
    logic [31:0]                  r_stat_hits;
    logic [31:0]                  r_stat_timeouts;

    // Rotating priority search: first valid requester at or above r_rr_ptr.
    // NUM_REQ is a power of two, so truncating the sum gives the wrap.
    always_comb begin
        w_found = 1'b0;
        w_pick  = r_rr_ptr;
        w_cand  = r_rr_ptr;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_cand = r_rr_ptr + c_IDX_W'(k);
            if (!w_found && bus.req_valid[w_cand]) begin
                w_found = 1'b1;
                w_pick  = w_cand;
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) r_state <= c_ST_INIT;
        else       r_state <= w_next_state;
    end

    // Next-state logic. In WAIT, lu_done has priority over the timeout.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_ST_INIT:  if (r_init_cnt == c_INIT_LAST) w_next_state = c_ST_IDLE;
            c_ST_IDLE:  if (w_found) w_next_state = c_ST_ISSUE;
            c_ST_ISSUE: w_next_state = c_ST_WAIT;
            c_ST_WAIT:  if (bus.lu_done || (r_wait_cnt == c_TO_LAST)) w_next_state = c_ST_RESP;
            c_ST_RESP:  w_next_state = c_ST_IDLE;
            default:    w_next_state = c_ST_INIT;
        endcase
    end

    // Pulse outputs decoded from state. These are zero in INIT, so they clear
    // in the cycle after reset.
    always_comb begin
        w_winner_oh    = {{(NUM_REQ-1){1'b0}}, 1'b1} << r_winner;
        bus.lu_req     = (r_state == c_ST_ISSUE);
        bus.req_grant  = (r_state == c_ST_ISSUE) ? w_winner_oh : '0;
        bus.resp_valid = (r_state == c_ST_RESP)  ? w_winner_oh : '0;
    end

    // Counters, latched lookup and response data, and statistics.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_init_cnt       <= '0;
            r_wait_cnt       <= '0;
            r_rr_ptr         <= '0;
            r_winner         <= '0;
            r_lu_dst_mac     <= '0;
            r_lu_src_mac     <= '0;
            r_lu_src_port    <= '0;
            r_resp_dst_ports <= '0;
            r_resp_hit       <= 1'b0;
            r_resp_timeout   <= 1'b0;
            r_stat_lookups   <= '0;
            r_stat_hits      <= '0;
            r_stat_timeouts  <= '0;
        end else begin
            case (r_state)
                c_ST_INIT: r_init_cnt <= r_init_cnt + 8'd1;
                c_ST_IDLE: begin
                    if (w_found) begin
                        r_winner      <= w_pick;
                        r_lu_dst_mac  <= bus.req_dst_mac[48*w_pick +: 48];
                        r_lu_src_mac  <= bus.req_src_mac[48*w_pick +: 48];
                        r_lu_src_port <= bus.req_src_port[NUM_OUTPUT_QUEUES*w_pick +: NUM_OUTPUT_QUEUES];
                    end
                end
                c_ST_ISSUE: begin
                    r_stat_lookups <= r_stat_lookups + 32'd1;
                    r_wait_cnt     <= '0;
                end
                c_ST_WAIT: begin
                    r_wait_cnt <= r_wait_cnt + 8'd1;
                    if (bus.lu_done) begin
                        // A LUT flagging both hit and miss is treated as a miss.
                        r_resp_dst_ports <= bus.lu_dst_ports;
                        r_resp_hit       <= bus.lu_hit & ~bus.lu_miss;
                        r_resp_timeout   <= 1'b0;
                    end else if (r_wait_cnt == c_TO_LAST) begin
                        // Flood to the default set, never back out the ingress port.
                        r_resp_dst_ports <= DEFAULT_MISS_OUTPUT_PORTS & ~r_lu_src_port;
                        r_resp_hit       <= 1'b0;
                        r_resp_timeout   <= 1'b1;
                    end
                end
                c_ST_RESP: begin
                    r_rr_ptr <= r_winner + c_IDX_W'(1);
                    if (r_resp_hit)     r_stat_hits     <= r_stat_hits + 32'd1;
                    if (r_resp_timeout) r_stat_timeouts <= r_stat_timeouts + 32'd1;
                end
                default: ;
            endcase
        end
    end

    assign bus.lu_dst_mac     = r_lu_dst_mac;
    assign bus.lu_src_mac     = r_lu_src_mac;
    assign bus.lu_src_port    = r_lu_src_port;
    assign bus.resp_dst_ports = r_resp_dst_ports;
    assign bus.resp_hit       = r_resp_hit;
    assign bus.resp_timeout   = r_resp_timeout;
    assign bus.stat_lookups   = r_stat_lookups;
    assign bus.stat_hits      = r_stat_hits;
    assign bus.stat_timeouts  = r_stat_timeouts;

endmodule
`default_nettype wire

// File: tb/tb_mac_lut_lookup_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mac_lut_lookup_arbiter
// Description : Directed bench for mac_lut_lookup_arbiter with a small LUT
//               responder model whose answer delay is set per step.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_mac_lut_lookup_arbiter;
    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    mac_lut_lookup_arbiter_if #(.NUM_REQ(4), .NUM_OUTPUT_QUEUES(8)) bus ();

    mac_lut_lookup_arbiter #(
        .NUM_REQ(4), .NUM_OUTPUT_QUEUES(8), .DEFAULT_MISS_OUTPUT_PORTS(8'h55),
        .INIT_CYCLES(64), .TIMEOUT_CYCLES(16)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    logic seen;

    // LUT model controls
    logic       lut_answer = 1'b0;
    int         lut_delay  = 2;
    logic [7:0] lut_ports  = 8'h00;
    logic       lut_hit    = 1'b0;
    logic       stray_done = 1'b0;
    int         cd         = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
    endtask

    task automatic run_to(input int n);
        while (cyc < n) tick();
    endtask

    // LUT responder: lu_done exactly lut_delay cycles after the lu_req cycle.
    initial begin
        bus.lu_done      = 1'b0;
        bus.lu_hit       = 1'b0;
        bus.lu_miss      = 1'b0;
        bus.lu_dst_ports = 8'h00;
        forever begin
            @(negedge clk);
            bus.lu_done = stray_done;
            if (bus.lu_req === 1'b1) begin
                cd = lut_delay;
            end else if (cd > 0) begin
                cd--;
                if (cd == 0 && lut_answer) begin
                    bus.lu_done      = 1'b1;
                    bus.lu_hit       = lut_hit;
                    bus.lu_miss      = ~lut_hit;
                    bus.lu_dst_ports = lut_ports;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.req_valid    = 4'b0001;
        bus.req_dst_mac  = '0;
        bus.req_src_mac  = '0;
        bus.req_src_port = '0;
        bus.req_dst_mac[0*48 +: 48]  = 48'hAABB_CCDD_EEF0;
        bus.req_src_mac[0*48 +: 48]  = 48'h0A00_0000_0001;
        bus.req_src_port[0*8 +: 8]   = 8'h01;
        bus.req_src_port[1*8 +: 8]   = 8'h02;
        bus.req_dst_mac[2*48 +: 48]  = 48'h0011_2233_4455;
        bus.req_src_port[2*8 +: 8]   = 8'h04;
        bus.req_src_port[3*8 +: 8]   = 8'h01;
        lut_answer = 1'b1; lut_delay = 2; lut_ports = 8'h02; lut_hit = 1'b0;

        // ---- A: reset state and init hold-off, first lookup from requester 0
        repeat (3) @(negedge clk);
        reset = 1'b0;
        cyc   = 0;
        check("rst_grant", bus.req_grant, 0);
        check("rst_resp_valid", bus.resp_valid, 0);
        check("rst_lu_req", bus.lu_req, 0);
        check("rst_stat_lookups", bus.stat_lookups, 0);
        check("rst_lu_dst_mac", bus.lu_dst_mac, 0);
        seen = 1'b0;
        while (cyc < 65) begin
            if (bus.req_grant !== 4'b0000) seen = 1'b1;
            tick();
        end
        check("no_early_grant", seen, 0);
        check("first_grant", bus.req_grant, 4'b0001);
        check("first_lu_req", bus.lu_req, 1);
        check("first_lu_dst_mac", bus.lu_dst_mac, 48'hAABB_CCDD_EEF0);
        check("first_lu_src_mac", bus.lu_src_mac, 48'h0A00_0000_0001);
        bus.req_valid = 4'b0000;
        tick();
        check("grant_one_cycle", bus.req_grant, 0);
        run_to(68);
        check("first_resp_valid", bus.resp_valid, 4'b0001);
        check("first_resp_ports", bus.resp_dst_ports, 8'h02);
        check("first_resp_hit", bus.resp_hit, 0);
        check("first_stat_lookups", bus.stat_lookups, 1);

        // ---- B: requester 2 hit
        run_to(69);
        bus.req_valid = 4'b0100;
        lut_ports = 8'h04; lut_hit = 1'b1;
        tick();
        check("hit_grant", bus.req_grant, 4'b0100);
        check("hit_lu_dst_mac", bus.lu_dst_mac, 48'h0011_2233_4455);
        check("hit_lu_src_port", bus.lu_src_port, 8'h04);
        bus.req_valid = 4'b0000;
        run_to(73);
        check("hit_resp_valid", bus.resp_valid, 4'b0100);
        check("hit_resp_ports", bus.resp_dst_ports, 8'h04);
        check("hit_resp_hit", bus.resp_hit, 1);
        check("hit_resp_timeout", bus.resp_timeout, 0);
        tick();
        check("hit_stat_hits", bus.stat_hits, 1);

        // ---- C: LUT silent, requester 3 times out
        lut_answer = 1'b0;
        bus.req_valid = 4'b1000;
        tick();
        check("to_grant", bus.req_grant, 4'b1000);
        bus.req_valid = 4'b0000;
        run_to(91);
        check("to_not_early", bus.resp_valid, 0);
        tick();
        check("to_resp_valid", bus.resp_valid, 4'b1000);
        check("to_resp_timeout", bus.resp_timeout, 1);
        check("to_resp_ports", bus.resp_dst_ports, 8'h54);
        check("to_resp_hit", bus.resp_hit, 0);
        tick();
        check("to_stat_timeouts", bus.stat_timeouts, 1);

        // ---- D: lu_done coincides with the timeout threshold
        lut_answer = 1'b1; lut_delay = 16; lut_ports = 8'hA0; lut_hit = 1'b1;
        bus.req_valid = 4'b0001;
        tick();
        check("tie_grant", bus.req_grant, 4'b0001);
        bus.req_valid = 4'b0000;
        run_to(111);
        check("tie_resp_valid", bus.resp_valid, 4'b0001);
        check("tie_resp_ports", bus.resp_dst_ports, 8'hA0);
        check("tie_resp_timeout", bus.resp_timeout, 0);
        tick();
        check("tie_stat_timeouts", bus.stat_timeouts, 1);
        check("tie_stat_hits", bus.stat_hits, 2);

        // ---- E: stray lu_done while idle
        stray_done = 1'b1;
        tick();
        stray_done = 1'b0;
        seen = 1'b0;
        while (cyc < 118) begin
            if (bus.resp_valid !== 4'b0000 || bus.lu_req !== 1'b0) seen = 1'b1;
            tick();
        end
        check("stray_no_resp", seen, 0);
        check("stray_stat_lookups", bus.stat_lookups, 4);
        check("stray_stat_hits", bus.stat_hits, 2);

        // ---- F: reset during WAIT, then full round robin
        lut_answer = 1'b0;
        bus.req_valid = 4'b0010;
        tick();
        check("rr1_grant", bus.req_grant, 4'b0010);
        run_to(122);
        reset = 1'b1;
        bus.req_valid = 4'b1111;
        lut_answer = 1'b1; lut_delay = 2; lut_ports = 8'h08; lut_hit = 1'b1;
        tick();
        check("mid_rst_resp_valid", bus.resp_valid, 0);
        check("mid_rst_grant", bus.req_grant, 0);
        check("mid_rst_stat_lookups", bus.stat_lookups, 0);
        check("mid_rst_stat_hits", bus.stat_hits, 0);
        check("mid_rst_stat_timeouts", bus.stat_timeouts, 0);
        check("mid_rst_lu_src_port", bus.lu_src_port, 0);
        check("mid_rst_resp_ports", bus.resp_dst_ports, 0);
        reset = 1'b0;
        cyc   = 0;
        seen  = 1'b0;
        while (cyc < 65) begin
            if (bus.req_grant !== 4'b0000 || bus.resp_valid !== 4'b0000) seen = 1'b1;
            tick();
        end
        check("rr_no_early_grant", seen, 0);
        check("rr_grant0", bus.req_grant, 4'b0001);
        run_to(68);
        check("rr_resp0", bus.resp_valid, 4'b0001);
        check("rr_resp0_ports", bus.resp_dst_ports, 8'h08);
        run_to(70);
        check("rr_grant1", bus.req_grant, 4'b0010);
        run_to(75);
        check("rr_grant2", bus.req_grant, 4'b0100);
        run_to(80);
        check("rr_grant3", bus.req_grant, 4'b1000);
        run_to(85);
        check("rr_grant0_again", bus.req_grant, 4'b0001);
        tick();
        check("rr_stat_lookups", bus.stat_lookups, 5);
        bus.req_valid = 4'b0000;
        run_to(88);
        check("rr_resp_last", bus.resp_valid, 4'b0001);
        tick();
        check("rr_stat_hits", bus.stat_hits, 5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/mac_lut_lookup_arbiter.md
# mac_lut_lookup_arbiter

Round-robin arbiter that shares one `mac_cam_lut` lookup engine between `NUM_REQ` independent requesters, such as per-port header parsers. It sequences each lookup: hold-off during LUT initialisation, request pulse, wait for done with timeout, then a tagged one-hot response. It sits between the ingress parsers and the learning CAM LUT. It also keeps lookup, hit and timeout statistics.

## Interface
- `NUM_REQ`, 4: number of requesters; power of two, 2..8.
- `NUM_OUTPUT_QUEUES`, 8: width of the port bitmap.
- `DEFAULT_MISS_OUTPUT_PORTS`, 8'h55: ports returned on timeout, before the source port is masked out.
- `INIT_CYCLES`, 64: cycles after reset before the first issue; covers the LUT fill.
- `TIMEOUT_CYCLES`, 16: maximum cycles in WAIT; range 3..255.

Ports:
- `clk` in 1: single clock.
- `reset` in 1: synchronous, active-high.
- `req_valid` in NUM_REQ: per-requester request; held until `req_grant`.
- `req_dst_mac` in NUM_REQ*48: requester i on bits [48i+47:48i].
- `req_src_mac` in NUM_REQ*48: same packing as `req_dst_mac`.
- `req_src_port` in NUM_REQ*NUM_OUTPUT_QUEUES: one-hot ingress port per requester.
- `req_grant` out NUM_REQ: one-hot, 1-cycle pulse; the request is accepted.
- `resp_valid` out NUM_REQ: one-hot, 1-cycle pulse to the winning requester.
- `resp_dst_ports` out NUM_OUTPUT_QUEUES: valid with `resp_valid`.
- `resp_hit` out 1: destination found in the LUT.
- `resp_timeout` out 1: the LUT did not answer.
- `lu_dst_mac`, `lu_src_mac` out 48: to the LUT; stable from IDLE-latch until RESP.
- `lu_src_port` out NUM_OUTPUT_QUEUES: to the LUT; same stability rule.
- `lu_req` out 1: 1-cycle lookup request pulse.
- `lu_dst_ports` in NUM_OUTPUT_QUEUES: LUT result.
- `lu_done` in 1: LUT result valid.
- `lu_hit` in 1: LUT hit flag.
- `lu_miss` in 1: LUT miss flag.
- `stat_lookups`, `stat_hits`, `stat_timeouts` out 32: wrapping counters.

## Operation
- States: INIT, IDLE, ISSUE, WAIT, RESP.
- INIT: an 8-bit counter runs from 0. At count INIT_CYCLES-1 the block moves to IDLE. No grant is issued in INIT.
- IDLE: if any `req_valid` is set, the winner is the first set bit searching upward from `rr_ptr`, wrapping NUM_REQ-1 to 0.
  - The winner's MACs and port are latched onto `lu_*`; the winner index is stored; go to ISSUE.
  - With no valid request, stay in IDLE.
- ISSUE: `lu_req`=1 and `req_grant[winner]`=1 for this cycle only. `stat_lookups`+1. Wait counter cleared; go to WAIT.
- WAIT: the wait counter increments each cycle.
  - On `lu_done`: capture `lu_dst_ports` and `lu_hit`, set timeout=0, go to RESP.
  - Otherwise, when the counter reaches TIMEOUT_CYCLES-1: capture `DEFAULT_MISS_OUTPUT_PORTS & ~lu_src_port`, hit=0, timeout=1, go to RESP.
  - If `lu_done` and the timeout condition occur in the same cycle, `lu_done` wins.
- RESP: `resp_valid[winner]`=1 for one cycle. `stat_hits`+1 if hit; `stat_timeouts`+1 if timeout. `rr_ptr` ← winner+1 mod NUM_REQ. Go to IDLE.
- `lu_done` outside WAIT is ignored and changes no state.
- `req_valid` deasserted before grant is a protocol violation; behaviour is undefined, but the FSM must not lock up.
- `resp_*` data holds its value until the next RESP. `lu_*` data holds its value until the next IDLE latch.

## Timing
- Reset (any cycle, including mid-lookup): state becomes INIT; counters, `rr_ptr`, all `req_grant`/`resp_valid`/`lu_req`/`resp_*`/`lu_*`/stat outputs become 0. Any in-flight lookup is dropped with no response.
- First `req_grant` can occur no earlier than cycle INIT_CYCLES+1 after reset release.
- Grant-to-response latency with a normally behaving LUT (done 2 cycles after `lu_req`):
  - ISSUE at cycle t.
  - `lu_done` at t+2.
  - `resp_valid` at t+3.
  - IDLE at t+4.
  - Next ISSUE earliest at t+5.
- Sustained throughput is one lookup per 5 cycles. This guarantees the LUT is back in IDLE before the next `lu_req`.
- On timeout, `resp_valid` is TIMEOUT_CYCLES+1 cycles after ISSUE.
- Exactly one `lu_req` is outstanding at any time.

## Test plan
- Reset, then `req_valid`=4'b0001 held from cycle 0 → no grant before cycle INIT_CYCLES+1. `req_grant`=0001, `lu_req` in the same cycle, `resp_valid`=0001 three cycles later.
- All four requesters valid continuously, LUT model answering in 2 cycles → grants in order 0,1,2,3,0, spaced 5 cycles apart. `stat_lookups`=5 afterwards.
- Requester 2, dst MAC 00:11:22:33:44:55, LUT returns hit with ports 8'h04 → `resp_valid`=0100, `resp_dst_ports`=8'h04, `resp_hit`=1, `resp_timeout`=0, `stat_hits`+1.
- LUT never asserts `lu_done`, `req_src_port`=8'h01 → `resp_timeout`=1, `resp_dst_ports`=8'h54, `resp_hit`=0 at ISSUE+17. `stat_timeouts`=1.
- `lu_done` arrives in the same cycle as the timeout threshold → LUT data returned, `resp_timeout`=0. A stray `lu_done` in IDLE → no `resp_valid`.
- `reset` asserted in WAIT → no `resp_valid`, all outputs 0 next cycle, INIT hold-off repeats, and arbitration restarts at requester 0.
